mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port-index constants and a small state-decode helper.
package mem_arb_pkg;

  // FSM state encoding (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Port indices as carried on grant_d
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // An access is in flight in every state except IDLE
  function automatic logic st_is_busy(input logic [1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction and data ports.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, ties alternate
// (the port not granted last wins); otherwise the data port wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic grant_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Select the winning port index from the current requests
  always_comb begin
    grant_o = PORT_I;
    if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Owner register resets to PORT_I, so the first tie goes to the data port
      grant_o = (last_grant_i == PORT_D) ? PORT_I : PORT_D;
`else
      grant_o = PORT_D;
`endif
    end else if (d_req_i) begin
      grant_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single shared memory
// interface. One access in flight at most: IDLE -> ISSUE -> WAIT -> RESP.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// inside mem_arb_pick; default build uses fixed data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction port (read only)
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_valid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // shared memory interface
  output logic                  m_request,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_valid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  // status
  output logic                  busy,
  output logic                  grant_d
);

  logic [1:0]            state_q,   state_d;
  logic                  owner_q,   owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  we_q,      we_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  pick_grant;

  mem_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_grant_i (owner_q),
    .grant_o      (pick_grant)
  );

  // Next-state logic: arbitration, request latching and read-data capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d = pick_grant;
          if (pick_grant == PORT_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            // Instruction fetches are always reads with zero write data
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // No timeout: the memory may stall indefinitely
        if (m_valid) begin
          if (owner_q == PORT_D) begin
            d_rdata_d = m_rdata;
          end else begin
            i_rdata_d = m_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything visible on ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode directly from registers, so they are glitch-free and
  // m_addr/m_we/m_wdata stay stable from ISSUE through WAIT.
  assign m_request = (state_q == ST_ISSUE);
  assign m_addr    = addr_q;
  assign m_we      = we_q;
  assign m_wdata   = wdata_q;
  assign i_valid   = (state_q == ST_RESP) && (owner_q == PORT_I);
  assign d_valid   = (state_q == ST_RESP) && (owner_q == PORT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = st_is_busy(state_q);
  assign grant_d   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and port
// responses are queued by the stimulus and checked by independent monitors.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_valid, d_valid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          m_request, m_we, m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy, grant_d;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_request(m_request), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_valid(m_valid), .m_rdata(m_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  typedef struct {
    logic          port;
    logic          chk;
    logic [DW-1:0] data;
  } resp_t;

  mreq_t         mreq_q[$];
  resp_t         resp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] mem [0:127];
  int            mem_lat  = 1;
  bit            mem_auto = 1'b1;
  int            stray_req = 0;
  logic [DW-1:0] stray_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_i_valid"},   64'(i_valid),   64'(0));
    check({tag, "_d_valid"},   64'(d_valid),   64'(0));
    check({tag, "_m_request"}, 64'(m_request), 64'(0));
    check({tag, "_m_we"},      64'(m_we),      64'(0));
    check({tag, "_m_addr"},    64'(m_addr),    64'(0));
    check({tag, "_m_wdata"},   64'(m_wdata),   64'(0));
    check({tag, "_i_rdata"},   64'(i_rdata),   64'(0));
    check({tag, "_d_rdata"},   64'(d_rdata),   64'(0));
    check({tag, "_grant_d"},   64'(grant_d),   64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
  endtask

  // Memory model: answers each m_request after mem_lat cycles, or emits stray pulses
  initial begin : responder
    int            stray_done;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    stray_done = 0;
    m_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_done < stray_req) begin
        stray_done++;
        m_valid = 1'b1;
        m_rdata = stray_data;
        @(negedge clk);
        m_valid = 1'b0;
        m_rdata = '0;
      end else if (m_request && mem_auto) begin
        a  = m_addr;
        w  = m_we;
        wd = m_wdata;
        repeat (mem_lat) @(negedge clk);
        if (w) mem[a] = wd;
        m_rdata = w ? '0 : mem[a];
        m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        m_rdata = '0;
      end
    end
  end

  // Monitor: every m_request must match the next expected memory access
  initial begin : mreq_mon
    mreq_t e;
    forever begin
      @(negedge clk);
      if (m_request) begin
        if (mreq_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mreq_unexpected: m_request with addr %0h, none expected", m_addr);
        end else begin
          e = mreq_q.pop_front();
          check("mreq_grant_d", 64'(grant_d), 64'(e.port));
          check("mreq_we",      64'(m_we),    64'(e.we));
          check("mreq_addr",    64'(m_addr),  64'(e.addr));
          check("mreq_wdata",   64'(m_wdata), 64'(e.wdata));
        end
      end
    end
  end

  // Monitor: every valid pulse must match the next expected port response
  initial begin : resp_mon
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_valid || d_valid) begin
        check("resp_one_valid", 64'(i_valid & d_valid), 64'(0));
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: i_valid=%0b d_valid=%0b, none expected", i_valid, d_valid);
        end else begin
          e = resp_q.pop_front();
          check("resp_port", 64'(d_valid), 64'(e.port));
          if (e.chk) check("resp_data", 64'(d_valid ? d_rdata : i_rdata), 64'(e.data));
        end
      end
    end
  end

  function automatic mreq_t mk_mreq(input logic port, input logic we,
                                    input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    mreq_t m;
    m.port = port; m.we = we; m.addr = addr; m.wdata = wdata;
    return m;
  endfunction

  function automatic resp_t mk_resp(input logic port, input logic chk, input logic [DW-1:0] data);
    resp_t r;
    r.port = port; r.chk = chk; r.data = data;
    return r;
  endfunction

  // One access on one port; cycles counts the request cycle as 1
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                           output int cycles);
    bit done;
    if (port == PORT_D) mreq_q.push_back(mk_mreq(PORT_D, we, addr, wdata));
    else                mreq_q.push_back(mk_mreq(PORT_I, 1'b0, addr, '0));
    resp_q.push_back(mk_resp(port, !(port == PORT_D && we), exp_data));
    @(negedge clk);
    if (port == PORT_D) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    cycles = 1;
    done = 1'b0;
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if ((port == PORT_D) ? d_valid : i_valid) done = 1'b1;
    end
    if (port == PORT_D) d_req = 1'b0;
    else                i_req = 1'b0;
    check("access_completed", 64'(done), 64'(1));
  endtask

  // Two back-to-back requests on one port, request held between them
  task automatic port_stream(input logic port, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int k;
    int guard;
    @(negedge clk);
    if (port == PORT_D) begin d_req = 1'b1; d_addr = a0; end
    else                begin i_req = 1'b1; i_addr = a0; end
    k = 0;
    guard = 0;
    while (k < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if ((port == PORT_D) ? d_valid : i_valid) begin
        k++;
        if (k < 2) begin
          if (port == PORT_D) d_addr = a1;
          else                i_addr = a1;
        end
      end
    end
    if (port == PORT_D) d_req = 1'b0;
    else                i_req = 1'b0;
    check("stream_completed", 64'(k), 64'(2));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int            cyc;
    int            mreqs;
    int            addr_bad;
    int            busy_bad;
    bit            seen;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[7'h05] = 32'hDEADBEEF;
    mem[7'h08] = 32'h08085A5A;
    mem[7'h20] = 32'h20200001;
    mem[7'h21] = 32'h21210002;
    mem[7'h30] = 32'h30300003;
    mem[7'h31] = 32'h31310004;

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Instruction read; stray data-port write inputs must not leak to memory
    d_we = 1'b1; d_wdata = 32'hFFFFFFFF;
    do_access(PORT_I, 1'b0, 7'h05, '0, 32'hDEADBEEF, cyc);
    check("iread_latency", 64'(cyc), 64'(4));
    check("iread_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));
    repeat (2) @(negedge clk);

    // Data write
    do_access(PORT_D, 1'b1, 7'h10, 32'h12345678, '0, cyc);
    check("dwrite_latency", 64'(cyc), 64'(4));
    check("dwrite_grant_d", 64'(grant_d), 64'(1));
    check("dwrite_i_rdata_kept", 64'(i_rdata), 64'(32'hDEADBEEF));
    d_we = 1'b0; d_wdata = '0;
    repeat (2) @(negedge clk);

    // Memory stall of 10 cycles with i_req toggling on the losing port
    mem_lat = 11;
    mreq_q.push_back(mk_mreq(PORT_D, 1'b0, 7'h08, '0));
    resp_q.push_back(mk_resp(PORT_D, 1'b1, 32'h08085A5A));
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 7'h08; i_addr = 7'h09;
    cyc = 0; mreqs = 0; addr_bad = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_valid) begin
        seen = 1'b1;
        d_req = 1'b0;
        i_req = 1'b0;
      end else begin
        if (m_request) mreqs++;
        if (m_addr != 7'h08) addr_bad++;
        if (!busy) busy_bad++;
        i_req = ~i_req;
      end
    end
    check("stall_done", 64'(seen), 64'(1));
    check("stall_cycles", 64'(cyc), 64'(13));
    check("stall_one_mreq", 64'(mreqs), 64'(1));
    check("stall_addr_stable", 64'(addr_bad), 64'(0));
    check("stall_busy", 64'(busy_bad), 64'(0));
    mem_lat = 1;
    repeat (3) @(negedge clk);
    check("stall_idle_after", 64'(busy), 64'(0));

    // Reset during WAIT, then a stray m_valid
    mem_auto = 1'b0;
    mreq_q.push_back(mk_mreq(PORT_I, 1'b0, 7'h0A, '0));
    @(negedge clk);
    i_req = 1'b1; i_addr = 7'h0A;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    rst_n = 1'b1;
    stray_data = 32'h5555AAAA;
    stray_req++;
    repeat (4) @(negedge clk);
    check("rst_stray_i_rdata", 64'(i_rdata), 64'(0));
    check("rst_stray_busy", 64'(busy), 64'(0));
    mem_auto = 1'b1;
    do_access(PORT_I, 1'b0, 7'h05, '0, 32'hDEADBEEF, cyc);
    check("after_reset_latency", 64'(cyc), 64'(4));
    repeat (2) @(negedge clk);

    // m_valid while IDLE must be ignored
    stray_data = 32'hCAFEF00D;
    stray_req++;
    repeat (4) @(negedge clk);
    check("idle_mvalid_i_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));
    check("idle_mvalid_d_rdata", 64'(d_rdata), 64'(0));
    check("idle_mvalid_busy", 64'(busy), 64'(0));

    // Two simultaneous requests on both ports, each repeated once
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d_we = 1'b0; d_wdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mreq_q.push_back(mk_mreq(PORT_D, 1'b0, 7'h20, '0));
    mreq_q.push_back(mk_mreq(PORT_I, 1'b0, 7'h30, '0));
    mreq_q.push_back(mk_mreq(PORT_D, 1'b0, 7'h21, '0));
    mreq_q.push_back(mk_mreq(PORT_I, 1'b0, 7'h31, '0));
    resp_q.push_back(mk_resp(PORT_D, 1'b1, 32'h20200001));
    resp_q.push_back(mk_resp(PORT_I, 1'b1, 32'h30300003));
    resp_q.push_back(mk_resp(PORT_D, 1'b1, 32'h21210002));
    resp_q.push_back(mk_resp(PORT_I, 1'b1, 32'h31310004));
`else
    mreq_q.push_back(mk_mreq(PORT_D, 1'b0, 7'h20, '0));
    mreq_q.push_back(mk_mreq(PORT_D, 1'b0, 7'h21, '0));
    mreq_q.push_back(mk_mreq(PORT_I, 1'b0, 7'h30, '0));
    mreq_q.push_back(mk_mreq(PORT_I, 1'b0, 7'h31, '0));
    resp_q.push_back(mk_resp(PORT_D, 1'b1, 32'h20200001));
    resp_q.push_back(mk_resp(PORT_D, 1'b1, 32'h21210002));
    resp_q.push_back(mk_resp(PORT_I, 1'b1, 32'h30300003));
    resp_q.push_back(mk_resp(PORT_I, 1'b1, 32'h31310004));
`endif
    fork
      port_stream(PORT_D, 7'h20, 7'h21);
      port_stream(PORT_I, 7'h30, 7'h31);
    join
    repeat (5) @(negedge clk);

    check("mreq_queue_drained", 64'(mreq_q.size()), 64'(0));
    check("resp_queue_drained", 64'(resp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
